// File: rtl/rotate_ddram_arbiter.sv
// Write-side DDRAM scheduler for the screen rotator: buffers single-pixel writes
// in a FIFO and fills idle port slots with a background framebuffer clear.
module rotate_ddram_arbiter #(
    parameter logic [6:0]  MEM_BASE   = 7'b0010010,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] FILL_COLOR = 32'h00000000
) (
    input  logic        CLK_VIDEO,
    input  logic        RESET_N,
    input  logic        px_wr,
    input  logic [1:0]  px_fb,
    input  logic [22:0] px_addr,
    input  logic [31:0] px_data,
    output logic        px_full,
    input  logic        clr_start,
    input  logic [1:0]  clr_fb,
    input  logic [19:0] clr_words,
    output logic        clr_busy,
    output logic [15:0] drop_cnt,
    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  fb;
        logic [20:0] addr;
        logic [31:0] data;
    } px_ent_t;

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

    px_ent_t       fifo_mem [FIFO_DEPTH];
    px_ent_t       head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          push, pop, slot, fifo_empty;

    clr_state_t    clr_state;
    logic [1:0]    clr_fb_q;
    logic [19:0]   clr_words_q, clr_ptr;
    logic          cur_last;
    logic          unused_addr_lsb;

    assign DDRAM_CLK       = CLK_VIDEO;
    assign DDRAM_BURSTCNT  = 8'd1;
    assign DDRAM_RD        = 1'b0;
    assign clr_busy        = (clr_state == CLR_RUN);
    assign unused_addr_lsb = ^px_addr[1:0];

    // A slot is any edge where the command register is free or being accepted.
    assign slot       = !DDRAM_WE || !DDRAM_BUSY;
    assign fifo_empty = (count == '0);
    assign push       = px_wr && !px_full;
    assign pop        = slot && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (push)
            fifo_mem[wr_ptr] <= {px_fb, px_addr[22:2], px_data};
    end

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            px_full     <= 1'b0;
            drop_cnt    <= '0;
            clr_state   <= CLR_IDLE;
            clr_fb_q    <= '0;
            clr_words_q <= '0;
            clr_ptr     <= '0;
            cur_last    <= 1'b0;
            DDRAM_WE    <= 1'b0;
            DDRAM_ADDR  <= '0;
            DDRAM_DIN   <= '0;
            DDRAM_BE    <= '0;
        end else begin
            count   <= count_nxt;
            px_full <= (count_nxt == FULL_CNT);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (px_wr && px_full && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;

            case (clr_state)
                CLR_IDLE:
                    if (clr_start && clr_words != '0) begin
                        clr_state   <= CLR_RUN;
                        clr_fb_q    <= clr_fb;
                        clr_words_q <= clr_words;
                        clr_ptr     <= '0;
                    end
                CLR_RUN:
                    if (slot && cur_last)
                        clr_state <= CLR_IDLE;
                default: clr_state <= CLR_IDLE;
            endcase

            // Pixels take priority; the clear pointer only moves when it wins a slot.
            if (slot) begin
                cur_last <= 1'b0;
                if (!fifo_empty) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    DDRAM_WE   <= 1'b1;
                    DDRAM_ADDR <= {MEM_BASE, head.fb, head.addr[20:1]};
                    DDRAM_BE   <= head.addr[0] ? 8'hF0 : 8'h0F;
                    DDRAM_DIN  <= {head.data, head.data};
                end else if (clr_state == CLR_RUN && clr_ptr != clr_words_q) begin
                    DDRAM_WE   <= 1'b1;
                    DDRAM_ADDR <= {MEM_BASE, clr_fb_q, clr_ptr};
                    DDRAM_BE   <= 8'hFF;
                    DDRAM_DIN  <= {FILL_COLOR, FILL_COLOR};
                    clr_ptr    <= clr_ptr + 1'b1;
                    cur_last   <= (clr_ptr == clr_words_q - 1'b1);
                end else begin
                    DDRAM_WE <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rotate_ddram_arbiter.sv
// Bench for rotate_ddram_arbiter: vector table plus scoreboard of accepted DDRAM commands.
module tb_rotate_ddram_arbiter;
    logic        CLK_VIDEO = 1'b0;
    logic        RESET_N   = 1'b0;
    logic        px_wr     = 1'b0;
    logic [1:0]  px_fb     = '0;
    logic [22:0] px_addr   = '0;
    logic [31:0] px_data   = '0;
    logic        px_full;
    logic        clr_start = 1'b0;
    logic [1:0]  clr_fb    = '0;
    logic [19:0] clr_words = '0;
    logic        clr_busy;
    logic [15:0] drop_cnt;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY = 1'b0;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        DDRAM_RD;

    rotate_ddram_arbiter dut (
        .CLK_VIDEO(CLK_VIDEO), .RESET_N(RESET_N),
        .px_wr(px_wr), .px_fb(px_fb), .px_addr(px_addr), .px_data(px_data), .px_full(px_full),
        .clr_start(clr_start), .clr_fb(clr_fb), .clr_words(clr_words), .clr_busy(clr_busy),
        .drop_cnt(drop_cnt), .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN),
        .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .DDRAM_RD(DDRAM_RD)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
        int          t;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  fb;
        logic [22:0] addr;
        logic [31:0] data;
        logic [28:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_din;
    } vec_t;

    exp_t         px_q[$];
    exp_t         mon_e;
    vec_t         vecs[6];
    int           n_cmp = 0, n_err = 0;
    int           cyc = 0, acc_cnt = 0, clr_cnt = 0, a0;
    logic [1:0]   clr_fb_e = '0;
    logic [19:0]  clr_ptr_e = '0;
    logic         prev_hold = 1'b0;
    logic [101:0] prev_vec = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_VIDEO);
        #1;
    endtask

    task automatic drv_px(input logic [1:0] fb, input logic [22:0] a, input logic [31:0] d,
                          input bit ex, input logic [28:0] ea, input logic [7:0] eb, input int lat);
        exp_t e;
        px_wr = 1'b1; px_fb = fb; px_addr = a; px_data = d;
        if (ex) begin
            e.addr = ea; e.be = eb; e.din = {d, d}; e.t = cyc; e.lat = lat;
            px_q.push_back(e);
        end
    endtask

    task automatic start_clr(input logic [1:0] fb, input logic [19:0] w, input bit ex);
        clr_start = 1'b1; clr_fb = fb; clr_words = w;
        if (ex) begin
            clr_fb_e = fb; clr_ptr_e = '0; clr_cnt = 0;
        end
        tick;
        clr_start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},   128'(DDRAM_WE), 128'(0));
        chk({tag, "_addr"}, 128'(DDRAM_ADDR), 128'(0));
        chk({tag, "_din"},  128'(DDRAM_DIN), 128'(0));
        chk({tag, "_be"},   128'(DDRAM_BE), 128'(0));
        chk({tag, "_full"}, 128'(px_full), 128'(0));
        chk({tag, "_cbusy"}, 128'(clr_busy), 128'(0));
        chk({tag, "_drop"}, 128'(drop_cnt), 128'(0));
        chk({tag, "_burst"}, 128'(DDRAM_BURSTCNT), 128'(1));
        chk({tag, "_rd"},   128'(DDRAM_RD), 128'(0));
    endtask

    always @(posedge CLK_VIDEO) cyc <= cyc + 1;

    // Commands seen with WE=1, BUSY=0 at the negedge are accepted at the next posedge.
    always @(negedge CLK_VIDEO) begin
        if (!RESET_N) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                chk("hold", 128'({DDRAM_WE, DDRAM_BE, DDRAM_ADDR, DDRAM_DIN}), 128'(prev_vec));
            prev_hold = DDRAM_WE && DDRAM_BUSY;
            prev_vec  = {DDRAM_WE, DDRAM_BE, DDRAM_ADDR, DDRAM_DIN};
            if (DDRAM_WE && !DDRAM_BUSY) begin
                acc_cnt++;
                if (DDRAM_BE == 8'hFF) begin
                    chk("clr_addr", 128'(DDRAM_ADDR), 128'({7'b0010010, clr_fb_e, clr_ptr_e}));
                    chk("clr_din", 128'(DDRAM_DIN), 128'(0));
                    clr_ptr_e = clr_ptr_e + 20'd1;
                    clr_cnt++;
                end else if (px_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL px_unexpected: got addr %0h expected no command", DDRAM_ADDR);
                end else begin
                    mon_e = px_q.pop_front();
                    chk("px_addr", 128'(DDRAM_ADDR), 128'(mon_e.addr));
                    chk("px_be", 128'(DDRAM_BE), 128'(mon_e.be));
                    chk("px_din", 128'(DDRAM_DIN), 128'(mon_e.din));
                    if (mon_e.lat != 0)
                        chk("px_lat", 128'(cyc - mon_e.t), 128'(mon_e.lat));
                end
            end
        end
    end

    initial begin
        vecs[0] = '{2'd1, 23'h000104, 32'hA5A5A5A5, 29'h04900020, 8'hF0, 64'hA5A5A5A5A5A5A5A5};
        vecs[1] = '{2'd0, 23'h000000, 32'h12345678, 29'h04800000, 8'h0F, 64'h1234567812345678};
        vecs[2] = '{2'd2, 23'h7FFFFC, 32'hDEADBEEF, 29'h04AFFFFF, 8'hF0, 64'hDEADBEEFDEADBEEF};
        vecs[3] = '{2'd1, 23'h000013, 32'hCAFEF00D, 29'h04900002, 8'h0F, 64'hCAFEF00DCAFEF00D};
        vecs[4] = '{2'd2, 23'h40000C, 32'h0000FFFF, 29'h04A80001, 8'hF0, 64'h0000FFFF0000FFFF};
        vecs[5] = '{2'd0, 23'h123458, 32'h89ABCDEF, 29'h0482468B, 8'h0F, 64'h89ABCDEF89ABCDEF};

        tick; tick;
        chk_reset_vals("rst");
        RESET_N = 1'b1;
        tick;

        // Table vectors, back to back at one per clock.
        for (int i = 0; i < 6; i++) begin
            drv_px(vecs[i].fb, vecs[i].addr, vecs[i].data, 1, vecs[i].e_addr, vecs[i].e_be, 2);
            tick;
        end
        px_wr = 1'b0;
        for (int k = 0; k < 20 && px_q.size() != 0; k++) tick;
        chk("tbl_drained", 128'(px_q.size()), 128'(0));

        // Single pixel: visible one cycle after the push edge, for one cycle.
        tick;
        drv_px(2'd1, 23'h000104, 32'hA5A5A5A5, 1, 29'h04900020, 8'hF0, 2);
        tick;
        px_wr = 1'b0;
        chk("sp_we_early", 128'(DDRAM_WE), 128'(0));
        tick;
        chk("sp_we", 128'(DDRAM_WE), 128'(1));
        chk("sp_addr", 128'(DDRAM_ADDR), 128'({7'b0010010, 2'd1, 20'h00020}));
        chk("sp_be", 128'(DDRAM_BE), 128'(8'hF0));
        chk("sp_din", 128'(DDRAM_DIN), 128'(64'hA5A5A5A5A5A5A5A5));
        tick;
        chk("sp_we_once", 128'(DDRAM_WE), 128'(0));

        // Back-pressure: one command parked in the port, then 20 writes against a stalled port.
        DDRAM_BUSY = 1'b1;
        drv_px(2'd0, 23'h000010, 32'h11110000, 1, 29'h04800002, 8'h0F, 0);
        tick;
        px_wr = 1'b0;
        tick;
        a0 = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            drv_px(2'd1, 23'(i * 8), 32'(32'h2000 + i), i < 16, 29'(29'h04900000 + i), 8'h0F, 0);
            tick;
            if (i == 14) chk("bp_full15", 128'(px_full), 128'(0));
            if (i == 15) chk("bp_full16", 128'(px_full), 128'(1));
        end
        px_wr = 1'b0;
        tick;
        chk("bp_drop", 128'(drop_cnt), 128'(4));
        chk("bp_stalled", 128'(acc_cnt - a0), 128'(0));
        DDRAM_BUSY = 1'b0;
        for (int k = 0; k < 40 && px_q.size() != 0; k++) tick;
        chk("bp_acc", 128'(acc_cnt - a0), 128'(17));
        chk("bp_full_clr", 128'(px_full), 128'(0));

        // Clear of 5 words.
        tick;
        a0 = acc_cnt;
        start_clr(2'd2, 20'd5, 1);
        for (int k = 0; k < 50 && clr_cnt < 5; k++) begin
            chk("clr_busy_run", 128'(clr_busy), 128'(1));
            tick;
        end
        chk("clr_busy_done", 128'(clr_busy), 128'(0));
        tick; tick; tick;
        chk("clr_cnt5", 128'(clr_cnt), 128'(5));
        chk("clr_acc5", 128'(acc_cnt - a0), 128'(5));

        // Pixels injected into a 100-word clear.
        a0 = acc_cnt;
        start_clr(2'd0, 20'd100, 1);
        for (int c = 0; c < 400 && clr_busy; c++) begin
            if (c == 10 || c == 40 || c == 70)
                drv_px(2'd3, 23'(c * 32 + 4), 32'(32'hBEEF0000 + c), 1,
                       29'(29'h04B00000 + c * 4), 8'hF0, 2);
            else
                px_wr = 1'b0;
            tick;
        end
        px_wr = 1'b0;
        tick; tick; tick;
        chk("arb_clr_cnt", 128'(clr_cnt), 128'(100));
        chk("arb_total", 128'(acc_cnt - a0), 128'(103));
        chk("arb_px_left", 128'(px_q.size()), 128'(0));

        // Zero-length clear does nothing.
        a0 = acc_cnt;
        start_clr(2'd1, 20'd0, 0);
        chk("zero_busy", 128'(clr_busy), 128'(0));
        tick; tick; tick;
        chk("zero_busy2", 128'(clr_busy), 128'(0));
        chk("zero_acc", 128'(acc_cnt - a0), 128'(0));

        // Second start mid-clear is ignored.
        a0 = acc_cnt;
        start_clr(2'd1, 20'd8, 1);
        tick; tick;
        start_clr(2'd3, 20'd50, 0);
        for (int k = 0; k < 60 && clr_busy; k++) tick;
        tick; tick;
        chk("restart_cnt", 128'(clr_cnt), 128'(8));
        chk("restart_acc", 128'(acc_cnt - a0), 128'(8));

        // Reset mid-clear with a stalled command and a queued pixel.
        DDRAM_BUSY = 1'b1;
        drv_px(2'd2, 23'h000040, 32'h5A5A5A5A, 0, '0, '0, 0);
        tick;
        drv_px(2'd2, 23'h000048, 32'h5A5A5A5B, 0, '0, '0, 0);
        tick;
        px_wr = 1'b0;
        start_clr(2'd0, 20'd50, 0);
        chk("rmid_busy", 128'(clr_busy), 128'(1));
        chk("rmid_drop_pre", 128'(drop_cnt), 128'(4));
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_vals("rmid");
        DDRAM_BUSY = 1'b0;
        tick; tick;
        RESET_N = 1'b1;
        a0 = acc_cnt;
        for (int k = 0; k < 10; k++) tick;
        chk("rmid_flush_acc", 128'(acc_cnt - a0), 128'(0));
        chk("rmid_flush_we", 128'(DDRAM_WE), 128'(0));
        chk("rmid_flush_cbusy", 128'(clr_busy), 128'(0));

        // Drop counter saturation: 65540 drops against a stalled, full FIFO.
        DDRAM_BUSY = 1'b1;
        drv_px(2'd0, 23'h0, 32'h00000077, 0, '0, '0, 0);
        for (int k = 0; k < 17 + 65534; k++) tick;
        chk("sat_fffe", 128'(drop_cnt), 128'(16'hFFFE));
        tick;
        chk("sat_ffff", 128'(drop_cnt), 128'(16'hFFFF));
        for (int k = 0; k < 5; k++) tick;
        chk("sat_hold", 128'(drop_cnt), 128'(16'hFFFF));
        px_wr = 1'b0;
        RESET_N = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
